key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_scan.sv | 151 +++++++++++++++
 tb/tb_key_scan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/key_scan.sv
// Four-key debouncer with press/release/long pulses and per-key LED toggle.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_scan #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key,
    output logic [3:0] key_state,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long,
    output logic [3:0] led_state
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        RELEASE_DEB
    } state_t;

    if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES) begin : g_bad_cfg
        $error("key_scan: illegal DEB_CYCLES/LONG_CYCLES");
    end

    logic [3:0] sync1;
    logic [3:0] sync2;

    // Inverted on capture so downstream logic sees 1 = pressed.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= ~key;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_key
        state_t        st;
        logic [DW-1:0] cnt;
        logic          ks;
        logic          kp;
        logic          kr;
        logic          kl;
        logic          led;

        // A transition fires on the DEB_CYCLES-th consecutive stable sample.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                st  <= IDLE;
                cnt <= '0;
                ks  <= 1'b0;
                kp  <= 1'b0;
                kr  <= 1'b0;
                led <= 1'b0;
            end else begin
                kp <= 1'b0;
                kr <= 1'b0;
                unique case (st)
                    IDLE: begin
                        if (sync2[i]) begin
                            st  <= PRESS_DEB;
                            cnt <= '0;
                        end
                    end
                    PRESS_DEB: begin
                        if (!sync2[i]) begin
                            st  <= IDLE;
                            cnt <= '0;
                        end else if (cnt == DEB_LAST - 1'b1) begin
                            st  <= HELD;
                            cnt <= '0;
                            ks  <= 1'b1;
                            kp  <= 1'b1;
                            led <= ~led;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!sync2[i]) begin
                            st  <= RELEASE_DEB;
                            cnt <= '0;
                        end
                    end
                    RELEASE_DEB: begin
                        if (sync2[i]) begin
                            st  <= HELD;
                            cnt <= '0;
                        end else if (cnt == DEB_LAST - 1'b1) begin
                            st  <= IDLE;
                            cnt <= '0;
                            ks  <= 1'b0;
                            kr  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        st  <= IDLE;
                        cnt <= '0;
                    end
                endcase
            end
        end

`ifdef KEY_LONG_PRESS_EN
        localparam int LW = $clog2(LONG_CYCLES);
        localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

        logic [LW-1:0] hcnt;
        logic          fired;

        // Saturating hold counter; fired blocks repeats within one hold.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                hcnt  <= '0;
                fired <= 1'b0;
                kl    <= 1'b0;
            end else begin
                kl <= 1'b0;
                if (!ks) begin
                    hcnt  <= '0;
                    fired <= 1'b0;
                end else if (hcnt != LONG_LAST) begin
                    hcnt <= hcnt + 1'b1;
                end else if (!fired) begin
                    kl    <= 1'b1;
                    fired <= 1'b1;
                end
            end
        end
`else
        assign kl = 1'b0;
`endif

        assign key_state[i]   = ks;
        assign key_press[i]   = kp;
        assign key_release[i] = kr;
        assign key_long[i]    = kl;
        assign led_state[i]   = led;
    end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with DEB_CYCLES=16, LONG_CYCLES=64.
// Checks latency, bounce rejection, toggles, long press and reset.
module tb_key_scan;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] key = 4'hF;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;
    logic [3:0] led_state;

    int errors = 0;
    int checks = 0;
    int press_tot = 0;
    int rel_tot = 0;

    key_scan #(
        .DEB_CYCLES (16),
        .LONG_CYCLES(64)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key        (key),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .led_state  (led_state)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        press_tot <= press_tot + $countones(key_press);
        rel_tot   <= rel_tot + $countones(key_release);
    end

    typedef struct {
        logic [3:0] k;
        int         cycles;
        logic [3:0] st;
        logic [3:0] led;
        int         np;
        int         nr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] k, input int cycles,
                       input logic [3:0] st, input logic [3:0] led,
                       input int np, input int nr);
        vec_t v;
        v.k = k;
        v.cycles = cycles;
        v.st = st;
        v.led = led;
        v.np = np;
        v.nr = nr;
        vecs.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " key_state"}, key_state, 4'h0);
        chk({tag, " key_press"}, key_press, 4'h0);
        chk({tag, " key_release"}, key_release, 4'h0);
        chk({tag, " key_long"}, key_long, 4'h0);
        chk({tag, " led_state"}, led_state, 4'h0);
    endtask

    initial begin
        int p0;
        int r0;
        int press_at;
        int long_at;
        int long_n;
        int hits;
        logic [3:0] hit_val;

        // Reset state
        tick(3);
        chk_zero("reset");
        sys_rst_n = 1'b1;
        tick(5);

        // Key 0: exact 18-clock latency on press and release
        key = 4'b1110;
        tick(17);
        chk("k0 state@17", key_state, 4'b0000);
        chk("k0 press@17", key_press, 4'b0000);
        tick(1);
        chk("k0 state@18", key_state, 4'b0001);
        chk("k0 press@18", key_press, 4'b0001);
        chk("k0 led@18", led_state, 4'b0001);
        tick(1);
        chk("k0 press@19", key_press, 4'b0000);
        tick(10);
        key = 4'b1111;
        tick(17);
        chk("k0 rel state@17", key_state, 4'b0001);
        chk("k0 rel pulse@17", key_release, 4'b0000);
        tick(1);
        chk("k0 rel state@18", key_state, 4'b0000);
        chk("k0 rel pulse@18", key_release, 4'b0001);
        chk("k0 rel led", led_state, 4'b0001);
        tick(10);

        // Key 2: two full press/release cycles
        add(4'b1011, 30, 4'b0100, 4'b0101, 1, 0);
        add(4'b1111, 30, 4'b0000, 4'b0101, 0, 1);
        add(4'b1011, 30, 4'b0100, 4'b0001, 1, 0);
        add(4'b1111, 30, 4'b0000, 4'b0001, 0, 1);
        // Key 1: 5-clock bounce for 100 clocks
        for (int i = 0; i < 10; i++) begin
            add(4'b1101, 5, 4'b0000, 4'b0001, 0, 0);
            add(4'b1111, 5, 4'b0000, 4'b0001, 0, 0);
        end
        add(4'b1111, 30, 4'b0000, 4'b0001, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            p0 = press_tot;
            r0 = rel_tot;
            key = vecs[i].k;
            tick(vecs[i].cycles);
            chk($sformatf("vec%0d state", i), key_state, vecs[i].st);
            chk($sformatf("vec%0d led", i), led_state, vecs[i].led);
            chk($sformatf("vec%0d presses", i), press_tot - p0, vecs[i].np);
            chk($sformatf("vec%0d releases", i), rel_tot - r0, vecs[i].nr);
        end

        // Key 3: 200-clock hold
        press_at = 0;
        long_at = 0;
        long_n = 0;
        key = 4'b0111;
        for (int c = 1; c <= 200; c++) begin
            tick(1);
            if (key_press[3]) press_at = c;
            if (key_long != 4'b0000) begin
                long_n++;
                long_at = c;
            end
        end
        chk("k3 press cycle", press_at, 18);
`ifdef KEY_LONG_PRESS_EN
        chk("k3 long count", long_n, 1);
        chk("k3 long delay", long_at - press_at, 64);
`else
        chk("k3 long count", long_n, 0);
`endif
        key = 4'b1111;
        tick(30);
        chk("k3 state after", key_state, 4'b0000);
        chk("k3 led after", led_state, 4'b1001);

        // All keys, reset mid-debounce, keys still held
        key = 4'b0000;
        tick(8);
        sys_rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        tick(3);
        chk_zero("midreset hold");
        sys_rst_n = 1'b1;
        press_at = 0;
        hits = 0;
        hit_val = 4'b0000;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (key_press != 4'b0000) begin
                hits++;
                press_at = c;
                hit_val = key_press;
            end
        end
        chk("all press events", hits, 1);
        chk("all press cycle", press_at, 18);
        chk("all press bits", hit_val, 4'b1111);
        chk("all led", led_state, 4'b1111);
        chk("all state", key_state, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
